// File: rtl/raster_timing_gen.sv
// raster_timing_gen: pixel/line counters, blank/sync generation, frame and
// line interrupts with sticky status, flash counter and frame-start strobe.
module raster_timing_gen #(
  parameter int unsigned H_TOTAL        = 384,
  parameter int unsigned V_TOTAL        = 312,
  parameter int unsigned HB_START       = 32,
  parameter int unsigned HS_START       = 48,
  parameter int unsigned HS_END         = 80,
  parameter int unsigned HB_END         = 112,
  parameter int unsigned VB_START       = 236,
  parameter int unsigned VB_END         = 260,
  parameter int unsigned VB_HC          = 108,
  parameter int unsigned VS_START       = 240,
  parameter int unsigned VS_END         = 244,
  parameter int unsigned ACTIVE_LINES   = 192,
  parameter int unsigned FRAME_INT_LINE = 244,
  parameter int unsigned INT_START      = 4,
  parameter int unsigned INT_LEN        = 128,
  parameter int unsigned N_LINT         = 2,
  parameter int unsigned FLASH_BITS     = 5
) (
  input  logic                  clk_sys,
  input  logic                  reset_n,
  input  logic                  ce_pix,
  input  logic                  ce_pixn,
  input  logic [8*N_LINT-1:0]   lint_no,
  input  logic [N_LINT-1:0]     lint_en,
  input  logic [N_LINT:0]       int_ack,
  output logic [8:0]            hc,
  output logic [8:0]            vc,
  output logic                  hblank,
  output logic                  hsync,
  output logic                  vblank,
  output logic                  vsync,
  output logic [N_LINT-1:0]     int_line,
  output logic                  int_frame,
  output logic [N_LINT:0]       int_status,
  output logic                  int_any,
  output logic                  flash,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = 9;
  localparam int unsigned CNT_LIM = 512;
  localparam int unsigned N_INT = N_LINT + 1;
  localparam logic [FLASH_BITS-1:0] FLASH_ONE = FLASH_BITS'(1);

  // Counters are fixed at 9 bits; reject geometries that cannot fit.
  if (H_TOTAL > CNT_LIM || V_TOTAL > CNT_LIM || HB_START >= CNT_LIM ||
      HS_START >= CNT_LIM || HS_END >= CNT_LIM || HB_END >= CNT_LIM ||
      VB_START >= CNT_LIM || VB_END >= CNT_LIM || VB_HC >= CNT_LIM ||
      VS_START >= CNT_LIM || VS_END >= CNT_LIM || ACTIVE_LINES >= CNT_LIM ||
      FRAME_INT_LINE >= CNT_LIM || INT_START + INT_LEN > CNT_LIM) begin : g_range_err
    $error("raster_timing_gen: timing parameter exceeds 9-bit counter range");
  end
  if (N_LINT < 1 || N_LINT > 8 || FLASH_BITS < 1) begin : g_cfg_err
    $error("raster_timing_gen: N_LINT must be 1..8 and FLASH_BITS >= 1");
  end

  logic [CNT_W-1:0]      r_hc;
  logic [CNT_W-1:0]      r_vc;
  logic [FLASH_BITS-1:0] r_flash_cnt;
  logic                  r_frame_start;
  logic                  r_hblank;
  logic                  r_hsync;
  logic                  r_vblank;
  logic                  r_vsync;
  logic [N_LINT-1:0]     r_int_line;
  logic                  r_int_frame;
  logic [N_INT-1:0]      r_int_status;
  logic                  r_int_any;

  logic                  w_hc_last;
  logic                  w_vc_last;
  logic                  w_window;
  logic [N_LINT-1:0]     w_line_lvl;
  logic                  w_frame_lvl;
  logic [N_INT-1:0]      w_lvl;
  logic [N_INT-1:0]      w_lvl_q;
  logic [N_INT-1:0]      w_status_nxt;

  assign w_hc_last = (r_hc == CNT_W'(H_TOTAL - 1));
  assign w_vc_last = (r_vc == CNT_W'(V_TOTAL - 1));

  // Pixel/line counters, flash counter and frame-start strobe on ce_pix.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_flash_cnt   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (ce_pix) begin
        if (w_hc_last) begin
          r_hc <= '0;
          if (w_vc_last) begin
            r_vc          <= '0;
            r_flash_cnt   <= r_flash_cnt + FLASH_ONE;
            r_frame_start <= 1'b1;
          end else begin
            r_vc <= r_vc + CNT_W'(1);
          end
        end else begin
          r_hc <= r_hc + CNT_W'(1);
        end
      end
    end
  end

  // Blank/sync update on ce_pixn, always against the pre-increment hc/vc.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hblank <= 1'b0;
      r_hsync  <= 1'b0;
      r_vblank <= 1'b0;
      r_vsync  <= 1'b0;
    end else if (ce_pixn) begin
      if (r_hc == CNT_W'(HB_START))    r_hblank <= 1'b1;
      else if (r_hc == CNT_W'(HB_END)) r_hblank <= 1'b0;
      if (r_hc == CNT_W'(HS_START))    r_hsync  <= 1'b1;
      else if (r_hc == CNT_W'(HS_END)) r_hsync  <= 1'b0;
      if (r_hc == CNT_W'(HS_START)) begin
        if (r_vc == CNT_W'(VS_START))    r_vsync <= 1'b1;
        else if (r_vc == CNT_W'(VS_END)) r_vsync <= 1'b0;
      end
      if (r_hc == CNT_W'(VB_HC)) begin
        if (r_vc == CNT_W'(VB_START))    r_vblank <= 1'b1;
        else if (r_vc == CNT_W'(VB_END)) r_vblank <= 1'b0;
      end
    end
  end

  // Interrupt level decode from the current counters and compare inputs.
  always_comb begin
    w_window    = (32'(r_hc) >= INT_START) && (32'(r_hc) < INT_START + INT_LEN);
    w_frame_lvl = w_window && (r_vc == CNT_W'(FRAME_INT_LINE));
    w_line_lvl  = '0;
    for (int i = 0; i < N_LINT; i++) begin
      w_line_lvl[i] = w_window && lint_en[i] && !r_vc[8] &&
                      (32'(lint_no[8*i +: 8]) < ACTIVE_LINES) &&
                      (lint_no[8*i +: 8] == r_vc[7:0]);
    end
    w_lvl        = {w_frame_lvl, w_line_lvl};
    w_lvl_q      = {r_int_frame, r_int_line};
    w_status_nxt = (r_int_status & ~int_ack) | (w_lvl & ~w_lvl_q);
  end

  // Registered interrupt levels and sticky status; a fresh set beats an ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_int_line   <= '0;
      r_int_frame  <= 1'b0;
      r_int_status <= '0;
      r_int_any    <= 1'b0;
    end else begin
      r_int_line   <= w_line_lvl;
      r_int_frame  <= w_frame_lvl;
      r_int_status <= w_status_nxt;
      r_int_any    <= |w_status_nxt;
    end
  end

  assign hc          = r_hc;
  assign vc          = r_vc;
  assign hblank      = r_hblank;
  assign hsync       = r_hsync;
  assign vblank      = r_vblank;
  assign vsync       = r_vsync;
  assign int_line    = r_int_line;
  assign int_frame   = r_int_frame;
  assign int_status  = r_int_status;
  assign int_any     = r_int_any;
  assign flash       = r_flash_cnt[FLASH_BITS-1];
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_raster_timing_gen.sv
// Bench for raster_timing_gen: hand-derived table, directed frame sequences
// and randomised enables/compares against a pixel-index reference model.
module tb_raster_timing_gen;

  // Short lines keep whole frames cheap; vertical timing is the default.
  localparam int H   = 64;
  localparam int V   = 300;
  localparam int HBS = 8;
  localparam int HSS = 12;
  localparam int HSE = 20;
  localparam int HBE = 28;
  localparam int VBH = 26;
  localparam int VBS = 236;
  localparam int VBE = 260;
  localparam int VSS = 240;
  localparam int VSE = 244;
  localparam int ACT = 192;
  localparam int FIL = 244;
  localparam int IST = 4;
  localparam int ILN = 32;
  localparam int FB  = 1;
  localparam int FRAME = H * V;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ce_pix;
  logic        ce_pixn;
  logic [15:0] lint_no;
  logic [1:0]  lint_en;
  logic [2:0]  int_ack;
  logic [8:0]  hc;
  logic [8:0]  vc;
  logic        hblank, hsync, vblank, vsync;
  logic [1:0]  int_line;
  logic        int_frame;
  logic [2:0]  int_status;
  logic        int_any;
  logic        flash;
  logic        frame_start;

  raster_timing_gen #(
    .H_TOTAL(H), .V_TOTAL(V), .HB_START(HBS), .HS_START(HSS), .HS_END(HSE),
    .HB_END(HBE), .VB_START(VBS), .VB_END(VBE), .VB_HC(VBH), .VS_START(VSS),
    .VS_END(VSE), .ACTIVE_LINES(ACT), .FRAME_INT_LINE(FIL), .INT_START(IST),
    .INT_LEN(ILN), .N_LINT(2), .FLASH_BITS(FB)
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .ce_pixn(ce_pixn),
    .lint_no(lint_no), .lint_en(lint_en), .int_ack(int_ack),
    .hc(hc), .vc(vc), .hblank(hblank), .hsync(hsync), .vblank(vblank),
    .vsync(vsync), .int_line(int_line), .int_frame(int_frame),
    .int_status(int_status), .int_any(int_any), .flash(flash),
    .frame_start(frame_start)
  );

  always #5 clk_sys = ~clk_sys;

  int total;
  int bad;

  // Reference model: position is a plain count of ce_pix pulses since reset.
  int         m_pix;
  logic       m_hb, m_hs, m_vb, m_vs, m_fs;
  logic [2:0] m_lvl;
  logic [2:0] m_status;

  function automatic int m_hc();
    return m_pix % H;
  endfunction

  function automatic int m_vc();
    return (m_pix / H) % V;
  endfunction

  function automatic logic m_flash();
    return 1'(((m_pix / FRAME) >> (FB - 1)) & 1);
  endfunction

  // Which interrupt levels the rules demand at a given position and setup.
  function automatic logic [2:0] lvl_of(input int h, input int v,
                                        input logic [15:0] no, input logic [1:0] en);
    logic [2:0] r;
    bit         win;
    int         cmp;
    win = (h >= IST) && (h < IST + ILN);
    for (int i = 0; i < 2; i++) begin
      cmp  = int'(no[8*i +: 8]);
      r[i] = win && en[i] && (cmp < ACT) && (cmp == v);
    end
    r[2] = win && (v == FIL);
    return r;
  endfunction

  task automatic model_reset();
    m_pix = 0;
    m_hb = 1'b0; m_hs = 1'b0; m_vb = 1'b0; m_vs = 1'b0; m_fs = 1'b0;
    m_lvl = '0;
    m_status = '0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_all(input string nm);
    logic [30:0] act;
    logic [30:0] exp;
    act = {hc, vc, hblank, hsync, vblank, vsync, int_line, int_frame,
           int_status, int_any, flash, frame_start};
    exp = {9'(m_hc()), 9'(m_vc()), m_hb, m_hs, m_vb, m_vs, m_lvl[1:0], m_lvl[2],
           m_status, |m_status, m_flash(), m_fs};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h (hc/vc model %0d/%0d)",
               nm, $time, act, exp, m_hc(), m_vc());
    end
  endtask

  // One clk_sys with the given enables/ack; model advances, then all outputs checked.
  task automatic step(input logic cp, input logic cpn, input logic [2:0] ack);
    logic [2:0] lvl;
    int h, v;
    h = m_hc();
    v = m_vc();
    ce_pix = cp; ce_pixn = cpn; int_ack = ack;
    lvl = lvl_of(h, v, lint_no, lint_en);
    if (cpn) begin
      if (h == HBS) m_hb = 1'b1;
      if (h == HBE) m_hb = 1'b0;
      if (h == HSS) m_hs = 1'b1;
      if (h == HSE) m_hs = 1'b0;
      if (h == HSS && v == VSS) m_vs = 1'b1;
      if (h == HSS && v == VSE) m_vs = 1'b0;
      if (h == VBH && v == VBS) m_vb = 1'b1;
      if (h == VBH && v == VBE) m_vb = 1'b0;
    end
    m_status = (m_status & ~ack) | (lvl & ~m_lvl);
    m_lvl = lvl;
    m_fs = 1'b0;
    if (cp) begin
      m_pix++;
      if (m_pix % FRAME == 0) m_fs = 1'b1;
    end
    @(posedge clk_sys);
    #1;
    ce_pix = 1'b0; ce_pixn = 1'b0; int_ack = '0;
    check_all("cycle");
  endtask

  typedef struct {
    int   adv;
    int   hc;
    int   vc;
    logic hb;
    logic hs;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int guard, fs_cnt, pos;
    int vs_rise, vs_fall, vb_rise, vb_fall, l0_cnt, l0_first, l1_cnt, fr_cnt;
    logic prv_vs, prv_vb;
    logic [2:0] ack;

    // Cumulative positions after reset with ce_pix/ce_pixn every clock.
    tbl[0] = '{12, 12, 0, 1'b1, 1'b0};
    tbl[1] = '{1,  13, 0, 1'b1, 1'b1};
    tbl[2] = '{7,  20, 0, 1'b1, 1'b1};
    tbl[3] = '{1,  21, 0, 1'b1, 1'b0};
    tbl[4] = '{7,  28, 0, 1'b1, 1'b0};
    tbl[5] = '{1,  29, 0, 1'b0, 1'b0};
    tbl[6] = '{35, 0,  1, 1'b0, 1'b0};
    tbl[7] = '{8,  8,  1, 1'b0, 1'b0};
    tbl[8] = '{1,  9,  1, 1'b1, 1'b0};

    total = 0; bad = 0;
    reset_n = 1'b0; ce_pix = 1'b0; ce_pixn = 1'b0;
    lint_no = '0; lint_en = '0; int_ack = '0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    check_all("reset_state");
    reset_n = 1'b1;

    // Frame 1: free run, channel 0 on line 10, channel 1 beyond active area.
    lint_no = {8'd192, 8'd10};
    lint_en = 2'b11;
    for (int k = 0; k < 9; k++) begin
      repeat (tbl[k].adv) step(1'b1, 1'b1, 3'b000);
      chk($sformatf("tbl%0d", k), int'({hc, vc, hblank, hsync}),
          (tbl[k].hc << 11) | (tbl[k].vc << 2) | (int'(tbl[k].hb) << 1) | int'(tbl[k].hs));
    end

    vs_rise = -1; vs_fall = -1; vb_rise = -1; vb_fall = -1;
    l0_cnt = 0; l0_first = -1; l1_cnt = 0; fr_cnt = 0; fs_cnt = 0;
    prv_vs = vsync; prv_vb = vblank; guard = 0;
    while (m_pix < FRAME && guard < FRAME + 16) begin
      step(1'b1, 1'b1, 3'b000);
      guard++;
      pos = m_vc() * 1000 + m_hc();
      if (vsync && !prv_vs && vs_rise < 0) vs_rise = pos;
      if (!vsync && prv_vs && vs_fall < 0) vs_fall = pos;
      if (vblank && !prv_vb && vb_rise < 0) vb_rise = pos;
      if (!vblank && prv_vb && vb_fall < 0) vb_fall = pos;
      prv_vs = vsync; prv_vb = vblank;
      if (int_line[0]) begin
        l0_cnt++;
        if (l0_first < 0) l0_first = pos;
      end
      if (int_line[1]) l1_cnt++;
      if (int_frame) fr_cnt++;
      if (frame_start) fs_cnt++;
    end
    chk("f1_vsync_rise", vs_rise, VSS * 1000 + HSS + 1);
    chk("f1_vsync_fall", vs_fall, VSE * 1000 + HSS + 1);
    chk("f1_vblank_rise", vb_rise, VBS * 1000 + VBH + 1);
    chk("f1_vblank_fall", vb_fall, VBE * 1000 + VBH + 1);
    chk("f1_lint0_len", l0_cnt, ILN);
    chk("f1_lint0_first", l0_first, 10 * 1000 + IST + 1);
    chk("f1_lint1_len", l1_cnt, 0);
    chk("f1_frame_len", fr_cnt, ILN);
    chk("f1_frame_start", fs_cnt, 1);
    chk("f1_wrap_pos", int'({hc, vc}), 0);
    chk("f1_flash", int'(flash), 1);
    chk("f1_status", int'(int_status), 5);

    // Frame 2: random enables, compares and acks.
    fs_cnt = 0; guard = 0;
    while (m_pix < 2 * FRAME && guard < 3 * FRAME) begin
      if ($urandom_range(0, 149) == 0) begin
        lint_no[7:0]  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'(m_vc() + int'($urandom_range(0, 1)));
        lint_no[15:8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                     : 8'(m_vc() + int'($urandom_range(0, 1)));
        lint_en = 2'($urandom_range(0, 3));
      end
      ack = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      step($urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, ack);
      if (frame_start) fs_cnt++;
      guard++;
    end
    chk("f2_frame_start", fs_cnt, 1);
    chk("f2_wrap_pos", int'({hc, vc}), 0);
    chk("f2_flash_wrap", int'(flash), 0);

    // Frame 3: two channels on one line, then ack colliding with a fresh set.
    step(1'b0, 1'b0, 3'b111);
    lint_no = {8'd50, 8'd50};
    lint_en = 2'b11;
    guard = 0;
    while (!(m_vc() == 50 && m_hc() == IST) && guard < FRAME) begin
      step(1'b1, 1'b1, 3'b000);
      guard++;
    end
    step(1'b1, 1'b1, 3'b001);
    chk("both_lines", int'(int_line), 3);
    chk("set_beats_ack", int'(int_status), 3);
    chk("any_set", int'(int_any), 1);
    step(1'b1, 1'b1, 3'b001);
    chk("ack_clears_bit0", int'(int_status), 2);

    // Mid-frame asynchronous reset.
    guard = 0;
    while (!(m_vc() == 100 && m_hc() == 40) && guard < FRAME) begin
      step(1'b1, 1'b1, 3'b000);
      guard++;
    end
    chk("pre_reset_pos", int'({vc, hc}), (100 << 9) | 40);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    ce_pix = 1'b1; ce_pixn = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check_all("held_in_reset");
    ce_pix = 1'b0; ce_pixn = 1'b0;
    lint_en = 2'b00;
    reset_n = 1'b1;

    // Post-reset frame: frame interrupt, its ack, and first frame_start timing.
    fs_cnt = 0; guard = 0;
    while (!(m_vc() == FIL && m_hc() == 10) && guard < FRAME) begin
      step(1'b1, 1'b1, 3'b000);
      if (frame_start) fs_cnt++;
      guard++;
    end
    chk("no_early_fs", fs_cnt, 0);
    chk("frame_int", int'(int_frame), 1);
    chk("frame_status", int'(int_status), 4);
    chk("frame_any", int'(int_any), 1);
    step(1'b1, 1'b1, 3'b100);
    chk("frame_ack_status", int'(int_status), 0);
    chk("frame_ack_any", int'(int_any), 0);
    chk("frame_int_held", int'(int_frame), 1);
    guard = 0;
    while (m_pix < FRAME && guard < FRAME) begin
      step(1'b1, 1'b1, 3'b000);
      if (frame_start) fs_cnt++;
      guard++;
    end
    chk("post_reset_fs", fs_cnt, 1);
    chk("post_reset_wrap", int'({hc, vc}), 0);
    chk("post_reset_flash", int'(flash), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/raster_timing_gen.md
Name: raster_timing_gen

Overview:
- Parametrised raster timing generator; the next-generation timing core for the video controller.
- Owns the pixel/line counters, blank/sync generation, the frame interrupt and N programmable line-interrupt comparators with sticky status and acknowledge, plus flash and frame-start strobes.
- Sits between the clock-enable generator and the video fetch/mixer logic; its counters drive fetch addressing and CPU contention.

Parameters:
- H_TOTAL, 384, pixel clocks per line; hc wraps at H_TOTAL-1.
- V_TOTAL, 312, lines per frame; vc wraps at V_TOTAL-1.
- HB_START, 32, hc where hblank sets.
- HS_START, 48, hc where hsync sets; also the hc where vsync changes.
- HS_END, 80, hc where hsync clears.
- HB_END, 112, hc where hblank clears.
- VB_START, 236, vblank set line; VB_END, 260, vblank clear line; both evaluated at hc==VB_HC.
- VB_HC, 108, hc of the vblank update.
- VS_START, 240, vsync set line; VS_END, 244, vsync clear line.
- ACTIVE_LINES, 192, line-int compare values >= this never fire.
- FRAME_INT_LINE, 244, line carrying the frame interrupt.
- INT_START, 4, first hc of the interrupt window.
- INT_LEN, 128, interrupt window length in pixel clocks.
- N_LINT, 2, number of line-interrupt comparators (1..8).
- FLASH_BITS, 5, flash counter width.

Ports:
- clk_sys  in  1  master clock.
- reset_n  in  1  asynchronous active-low reset.
- ce_pix  in  1  counter-advance enable (positive pixel phase).
- ce_pixn  in  1  sync/blank update enable (negative pixel phase).
- lint_no  in  8*N_LINT  line-compare values; channel i occupies bits [8i+7:8i].
- lint_en  in  N_LINT  per-channel enable.
- int_ack  in  N_LINT+1  write-1-to-clear pulse for status; bit N_LINT is frame.
- hc  out  9  horizontal counter.
- vc  out  9  vertical counter.
- hblank, hsync, vblank, vsync  out  1 each  timing outputs.
- int_line  out  N_LINT  level line interrupts, one per channel.
- int_frame  out  1  level frame interrupt.
- int_status  out  N_LINT+1  sticky interrupt status.
- int_any  out  1  OR of int_status.
- flash  out  1  MSB of flash counter.
- frame_start  out  1  one-clk_sys pulse on frame wrap.

Behaviour:
- Reset (async, reset_n low): hc, vc, flash counter, all blanks/syncs, int_line, int_frame, int_status and frame_start are 0.
- On ce_pix: if hc==H_TOTAL-1 then hc<=0 and vc advances; at vc==V_TOTAL-1, vc<=0, the flash counter increments (wraps) and frame_start pulses for one clk.
- Otherwise on ce_pix, hc increments.
- Nothing advances without ce_pix.
- On ce_pixn, all compares use the current (pre-increment) hc/vc:
  - hblank sets at HB_START and clears at HB_END.
  - hsync sets at HS_START and clears at HS_END.
  - At HS_START: vsync<=1 if vc==VS_START; vsync<=0 if vc==VS_END.
  - At VB_HC: vblank<=1 if vc==VB_START; vblank<=0 if vc==VB_END.
- If ce_pix and ce_pixn are high in the same clk, both act; ce_pixn sees the old hc.
- Interrupts are evaluated every clk_sys, registered, 1-clk latency from the hc/vc change.
- Window: INT_START <= hc < INT_START+INT_LEN.
- int_line[i] = window & lint_en[i] & (lint_no[i] < ACTIVE_LINES) & (lint_no[i]==vc[7:0]) & (vc < 256).
- int_frame = window & (vc==FRAME_INT_LINE).
- lint_no and lint_en changes take effect on the next clk, including mid-window; deassertion mid-window is allowed.
- Several channels matching the same line all assert.
- int_status bit sets on the rising edge of its level interrupt and clears on the matching int_ack bit.
- If set and ack occur in the same clk, set wins.
- int_any is registered with int_status.
- Widths: hc/vc are fixed at 9 bits; parameters must be < 512. Exceeding this is an elaboration error (assert).
- A reset mid-frame restarts at hc=0, vc=0 with no spurious frame_start.

Test Plan:
- Reset release, 384*312 ce_pix pulses -> vc returns to 0; exactly one frame_start; flash counter=1.
- Free run, sample at ce_pixn -> hsync high for hc 49..80, hblank high for hc 33..112 (one-ce lag); vsync high from line 240 hc 49 to line 244 hc 48.
- lint_no[0]=10 and lint_en=01 -> int_line[0] high for exactly 128 ce_pix periods on line 10, starting 1 clk after hc==4; int_line[1] stays 0. With lint_no[0]=192, it never fires.
- Both channels set to 50 -> both int_line bits assert together; status 011; int_ack=001 in the clk of a fresh set on the same bit -> the bit stays 1.
- vc==244 -> int_frame high in the window and status[N_LINT]=1; int_ack bit 2 -> status clears and int_any drops the next clk.
- Assert reset_n low at vc=100, hc=200 -> all outputs 0 asynchronously; after release, counting restarts from 0,0 and the first frame_start comes after a full frame.
